// File: rtl/periph_pkg.sv
// Shared packet layout for peripheral-to-host packets: field positions and the packed view.
package periph_pkg;

  localparam int unsigned PKT_W     = 32;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned CFG_BIT   = 28;
  localparam int unsigned NBYTES_HI = 27;
  localparam int unsigned NBYTES_LO = 26;
  localparam int unsigned RSVD_HI   = 25;
  localparam int unsigned RSVD_LO   = 24;
  localparam int unsigned DATA_HI   = 23;
  localparam int unsigned DATA_LO   = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              cfg;
    logic [1:0]        nbytes;
    logic [1:0]        rsvd;
    logic [23:0]       data;
  } periph_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; caller guarantees push is only issued when there is room.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Occupancy tracked independently of the wrapping pointers.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/periph_tx_buffer.sv
// Buffers peripheral packets toward the host-link arbiter: validates, stamps the peripheral
// address, queues in a FWFT FIFO and tracks sticky drop flags with saturating drop counters.
module periph_tx_buffer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned PERIPH_ADDR = 0,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-ADDR_W-1:0]   packet_in,
  input  logic                      data_valid,
  output logic [WIDTH-1:0]          tx_packet,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic                      clr_status,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic                      malformed,
  output logic [CNT_W-1:0]          ovf_drops,
  output logic [CNT_W-1:0]          bad_drops
);

  import periph_pkg::*;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_c;
  logic             push_c;
  logic             bad_pkt_c;
  logic             ovf_drop_c;
  logic             bad_drop_c;
  logic [WIDTH-1:0] stamped_c;

  logic             overflow_q, overflow_d;
  logic             malformed_q, malformed_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;

  // Classify the candidate and build the stored word with reserved bits cleared.
  always_comb begin
    bad_pkt_c = !packet_in[CFG_BIT] && (packet_in[NBYTES_HI:NBYTES_LO] == 2'b00);
    stamped_c = {ADDR_W'(PERIPH_ADDR), packet_in};
    stamped_c[RSVD_HI:RSVD_LO] = 2'b00;
    pop_c      = tx_valid && tx_ready;
    push_c     = data_valid && !bad_pkt_c && (!fifo_full || pop_c);
    ovf_drop_c = data_valid && !bad_pkt_c && fifo_full && !pop_c;
    bad_drop_c = data_valid && bad_pkt_c;
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wr_data (stamped_c),
    .pop     (pop_c),
    .rd_data (tx_packet),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A drop coinciding with clr_status restarts the counter at one.
  always_comb begin
    overflow_d  = overflow_q;
    malformed_d = malformed_q;
    ovf_cnt_d   = ovf_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (clr_status) begin
      overflow_d  = 1'b0;
      malformed_d = 1'b0;
      ovf_cnt_d   = '0;
      bad_cnt_d   = '0;
    end
    if (ovf_drop_c) begin
      overflow_d = 1'b1;
      if (clr_status)          ovf_cnt_d = CNT_W'(1);
      else if (~&ovf_cnt_q)    ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
    if (bad_drop_c) begin
      malformed_d = 1'b1;
      if (clr_status)          bad_cnt_d = CNT_W'(1);
      else if (~&bad_cnt_q)    bad_cnt_d = bad_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      malformed_q <= 1'b0;
      ovf_cnt_q   <= '0;
      bad_cnt_q   <= '0;
    end else begin
      overflow_q  <= overflow_d;
      malformed_q <= malformed_d;
      ovf_cnt_q   <= ovf_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign tx_valid  = !fifo_empty;
  assign overflow  = overflow_q;
  assign malformed = malformed_q;
  assign ovf_drops = ovf_cnt_q;
  assign bad_drops = bad_cnt_q;

endmodule
